// File: rtl/accum_sequencer.sv
// fp16 accumulation job sequencer with valid/ready operand and result ports.
// Includes the combinational fp16 adder used on the accumulate path.
module adder_IEEE754_16bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  logic        b_sgn;
  logic        a_nan;
  logic        b_nan;
  logic        a_inf;
  logic        b_inf;
  logic        swap;
  logic        sl;
  logic        ss;
  logic [4:0]  el;
  logic [4:0]  es;
  logic [9:0]  ml;
  logic [9:0]  ms;
  logic [10:0] sig_l;
  logic [10:0] sig_s;
  logic [5:0]  exl;
  logic [5:0]  exs;
  logic [5:0]  d;
  logic [3:0]  dc;
  logic [27:0] al;
  logic [13:0] ml14;
  logic [13:0] ms14;
  logic        eff_sub;
  logic [14:0] s;
  logic [3:0]  lz;
  logic [5:0]  lim;
  logic [3:0]  shl;
  logic [13:0] n;
  logic [6:0]  e;
  logic        rup;
  logic [11:0] rm;
  logic [6:0]  ef;
  logic [9:0]  ff;
  logic        sgn;

  always_comb begin
    b_sgn = b[15] ^ sub;
    a_nan = (&a[14:10]) && (|a[9:0]);
    b_nan = (&b[14:10]) && (|b[9:0]);
    a_inf = (&a[14:10]) && !(|a[9:0]);
    b_inf = (&b[14:10]) && !(|b[9:0]);

    swap = b[14:0] > a[14:0];
    sl = swap ? b_sgn : a[15];
    ss = swap ? a[15] : b_sgn;
    {el, ml} = swap ? b[14:0] : a[14:0];
    {es, ms} = swap ? a[14:0] : b[14:0];

    sig_l = {|el, ml};
    sig_s = {|es, ms};
    exl = (el == 5'd0) ? 6'd1 : {1'b0, el};
    exs = (es == 5'd0) ? 6'd1 : {1'b0, es};
    d  = exl - exs;
    dc = (d > 6'd15) ? 4'd15 : d[3:0];

    // Three guard bits; everything shifted past them collapses to sticky.
    al   = {sig_s, 3'b000, 14'b0} >> dc;
    ms14 = al[27:14] | {13'b0, |al[13:0]};
    ml14 = {sig_l, 3'b000};

    eff_sub = sl ^ ss;
    s = eff_sub ? ({1'b0, ml14} - {1'b0, ms14})
                : ({1'b0, ml14} + {1'b0, ms14});

    lz = 4'd14;
    for (int i = 0; i < 14; i++) begin
      if (s[i]) lz = 4'(13 - i);
    end

    lim = exl - 6'd1;
    shl = 4'd0;
    e   = {1'b0, exl};
    if (s[14]) begin
      n = {s[14:2], s[1] | s[0]};
      e = e + 7'd1;
    end else begin
      shl = ({2'b0, lz} > lim) ? lim[3:0] : lz;
      n   = s[13:0] << shl;
      e   = e - {3'b0, shl};
    end

    rup = n[2] & (n[1] | n[0] | n[3]);
    rm  = {1'b0, n[13:3]} + {11'b0, rup};
    if (rm[11]) begin
      ef = e + 7'd1;
      ff = 10'd0;
    end else begin
      ef = rm[10] ? e : 7'd0;
      ff = rm[9:0];
    end

    sgn = (s == 15'd0 && eff_sub) ? 1'b0 : sl;
    if (ef >= 7'd31) sum = {sgn, 5'h1f, 10'h0};
    else             sum = {sgn, ef[4:0], ff};

    if (a_nan || b_nan)
      sum = 16'h7e00;
    else if (a_inf && b_inf && (a[15] != b_sgn))
      sum = 16'h7e00;
    else if (a_inf)
      sum = {a[15], 5'h1f, 10'h0};
    else if (b_inf)
      sum = {b_sgn, 5'h1f, 10'h0};
  end

endmodule

module accum_sequencer #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             clear,
  output logic             busy,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] elem_count
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] add_sum;

  adder_IEEE754_16bit #(
    .WIDTH(WIDTH)
  ) u_add (
    .a  (sum_q),
    .b  (in_data),
    .sub(1'b0),
    .sum(add_sum)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      sum_d   = '0;
      rem_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            sum_d = '0;
            cnt_d = '0;
            rem_d = len;
            state_d = (len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sum_d = add_sum;
            rem_d = rem_q - 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (rem_q == CNT_W'(1)) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == ACCUM);
    vld_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sum_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
    end
  end

  // An abort must never let the operand on the bus be taken.
  assign in_ready   = rdy_q & ~clear;
  assign busy       = busy_q;
  assign out_valid  = vld_q;
  assign out_data   = sum_q;
  assign elem_count = cnt_q;

endmodule

// File: doc/accum_sequencer.md
# accum_sequencer

Sequencing controller for the fp16 accumulation datapath in the spatial array. It accepts a job length, streams exactly that many IEEE754 half-precision operands through a valid/ready handshake into an internal `adder_IEEE754_16bit` instance (`sub` tied to 0), and presents the final sum on a valid/ready result port. It sits between the operand feeder and the result collector of a processing element. It replaces ad-hoc enable/reset toggling of a bare accumulator with a defined job protocol.

## Interface
- `WIDTH`, 16, operand/sum width (fp16; the adder instance uses the same value)
- `CNT_W`, 8, width of the length and count fields
- `clk` in 1: single clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `start` in 1: job request pulse, sampled only in IDLE
- `len` in CNT_W: operand count for the job, latched on accepted `start`
- `clear` in 1: synchronous abort, returns to IDLE from any state
- `busy` out 1: high in ACCUM and DONE
- `in_valid` in 1: operand valid
- `in_data` in WIDTH: fp16 operand
- `in_ready` out 1: operand accepted when `in_valid && in_ready`
- `out_valid` out 1: result valid
- `out_data` out WIDTH: accumulated fp16 sum
- `out_ready` in 1: result consumed when `out_valid && out_ready`
- `elem_count` out CNT_W: operands accepted in the current/last job

## Operation
- States: IDLE, ACCUM, DONE. `sum_reg` (WIDTH), `remaining` (CNT_W), `elem_count` (CNT_W) registers.
- IDLE: `in_ready`=0, `out_valid`=0, `busy`=0. On `start`: latch `len`, clear `sum_reg` to 0x0000, clear `elem_count`. If `len`==0, go to DONE (result 0x0000). Otherwise set `remaining`=`len` and go to ACCUM.
- ACCUM: `in_ready`=1. On handshake:
  - `sum_reg` <= adder(`sum_reg`, `in_data`)
  - `remaining` decrements; `elem_count` increments
  - if `remaining`==1, go to DONE
  - `in_valid` low: hold all state (no bubbles counted).
- DONE: `out_valid`=1, `in_ready`=0. On `out_ready`, go to IDLE. `out_valid`/`out_data` stable until consumed.
- `out_data` = `sum_reg` combinationally in all states. In IDLE it holds the last result. It is not a valid indication.
- `start` is ignored outside IDLE, including in DONE on the same cycle as `out_ready`. A new job needs `start` in IDLE.
- `clear` has priority over every other event, including a same-cycle operand or result handshake:
  - next state IDLE; `sum_reg` and `elem_count` go to 0.
  - the operand presented that cycle is not accepted (`in_ready` is forced to 0 while `clear` is high).
- Arithmetic: fp16 rounding, overflow to inf and NaN propagation are exactly those of `adder_IEEE754_16bit`. The controller adds no saturation. `len` is unsigned, max 2^CNT_W−1.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE. `sum_reg`, `remaining` and `elem_count` are 0. Outputs `busy`, `in_ready`, `out_valid`, `out_data` and `elem_count` are all 0. Reset mid-job discards the job.
- `start` accepted at edge N → ACCUM at N+1, `in_ready` high during cycle N+1.
- Throughput: one operand per cycle. The adder is combinational and the sum is registered at the handshake edge.
- Last operand handshake at edge M → `out_valid`=1 from cycle M+1 with the final sum.
- `len`==0: `start` at edge N → `out_valid`=1 from cycle N+1, `out_data`=0x0000.
- Minimum job latency: `start` to `out_valid` is `len`+1 cycles with back-to-back operands.
- With `out_ready` held high, DONE lasts exactly 1 cycle. The next `start` is accepted at the earliest one cycle after returning to IDLE.

## Test plan
- Basic job: `len`=3, operands 0x3C00, 0x4000, 0x4200 back-to-back, `out_ready`=1 → `out_data`=0x4600, `out_valid` for 1 cycle, `elem_count`=3, `busy` low afterward.
- Gapped stream and backpressure: `len`=2, operands 0x3C00, then 0x3800 with 3 idle cycles between them, `out_ready` low for 4 cycles → `in_ready` stays high through the gap. Result 0x3E00 is held stable with `out_valid` high until `out_ready`.
- Zero length: `len`=0 → `out_valid` one cycle after `start`, `out_data`=0x0000, `elem_count`=0, `in_ready` never asserted.
- Ignored start: pulse `start` with `len`=5 mid-ACCUM of a `len`=2 job (0x4000, 0x4000) → job ends after 2 operands with 0x4400. The second start has no effect.
- `clear` priority: assert `clear` in the same cycle as the 2nd operand handshake of a `len`=4 job → IDLE next cycle, `elem_count`=0, `out_data`=0x0000, no `out_valid`. A following `len`=1 job of 0x3C00 yields 0x3C00.
- Async reset mid-job: drop `reset_n` between clock edges during ACCUM → all outputs 0 immediately, state IDLE after release, and a subsequent job behaves as in the basic-job case.
